// File: rtl/core_pkg.sv
// core_pkg: shared writeback encodings, load funct3 codes and FSM state type.
package core_pkg;
  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  typedef enum logic {RUN, WAIT_LOAD} wb_state_t;
endpackage

// File: rtl/load_align.sv
// load_align: picks the addressed byte/half of a load word and sign- or zero-extends it.
module load_align
  import core_pkg::*;
#(
  parameter int register_size = 32
) (
  input  logic [register_size-1:0] word,
  input  logic [1:0]               offset,
  input  logic [2:0]               funct3,
  output logic [register_size-1:0] aligned
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = word[{offset, 3'b000} +: 8];
  assign h = offset[1] ? word[31:16] : word[15:0];
  always_comb begin
    aligned = funct3 == F3_LB  ? {{(register_size-8){b[7]}}, b} :
              funct3 == F3_LBU ? {{(register_size-8){1'b0}}, b} :
              funct3 == F3_LH  ? {{(register_size-16){h[15]}}, h} :
              funct3 == F3_LHU ? {{(register_size-16){1'b0}}, h} :
              word;
  end
endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB register, load-wait FSM, result select and register file write port.
module writeback_stage
  import core_pkg::*;
#(
  parameter int address_width = 5,
  parameter int register_size = 32
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     valid_i,
  input  logic                     reg_write_i,
  input  logic [address_width-1:0] rd_addr_i,
  input  logic [1:0]               wb_sel_i,
  input  logic [2:0]               funct3_i,
  input  logic [register_size-1:0] alu_result_i,
  input  logic [register_size-1:0] pc_plus4_i,
  input  logic                     flush_i,
  input  logic [register_size-1:0] dmem_rdata_i,
  input  logic                     dmem_rvalid_i,
  output logic                     stall_o,
  output logic [address_width-1:0] writereg_addr_o,
  output logic [register_size-1:0] data_o,
  output logic                     data_write_o,
  output logic [31:0]              retire_count_o
);
  logic                     valid;
  logic                     reg_write;
  logic [address_width-1:0] rd;
  logic [1:0]               wb_sel;
  logic [2:0]               funct3;
  logic [register_size-1:0] alu_result;
  logic [register_size-1:0] pc_plus4;
  logic                     flush_pending;
  logic                     is_load;
  logic                     completing;
  logic                     bubble;
  logic [register_size-1:0] load_value;
  wb_state_t                state;
  wb_state_t                state_next;
  load_align #(.register_size(register_size)) u_align (
    .word    (dmem_rdata_i),
    .offset  (alu_result[1:0]),
    .funct3  (funct3),
    .aligned (load_value)
  );
  assign is_load = valid & (wb_sel == WB_LOAD);
  always_comb begin
    stall_o    = state == WAIT_LOAD ? !dmem_rvalid_i : is_load & !dmem_rvalid_i;
    state_next = stall_o ? WAIT_LOAD : RUN;
    completing = valid & !stall_o;
    bubble     = flush_i | flush_pending | !valid_i;
  end
  assign writereg_addr_o = rd;
  assign data_write_o    = completing & reg_write & (rd != '0);
  assign data_o          = wb_sel == WB_LOAD ? load_value : wb_sel == WB_PC4 ? pc_plus4 : alu_result;
  // A stalled load is never killed; a flush seen during the stall turns the next capture into a bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= RUN;
      valid          <= 1'b0;
      reg_write      <= 1'b0;
      rd             <= '0;
      wb_sel         <= WB_ALU;
      funct3         <= '0;
      alu_result     <= '0;
      pc_plus4       <= '0;
      flush_pending  <= 1'b0;
      retire_count_o <= '0;
    end else begin
      state <= state_next;
      if (completing) retire_count_o <= retire_count_o + 32'd1;
      if (stall_o) begin
        if (flush_i) flush_pending <= 1'b1;
      end else begin
        flush_pending <= 1'b0;
        valid         <= !bubble;
        reg_write     <= !bubble & reg_write_i;
        rd            <= bubble ? '0 : rd_addr_i;
        wb_sel        <= bubble ? WB_ALU : wb_sel_i;
        funct3        <= bubble ? '0 : funct3_i;
        alu_result    <= bubble ? '0 : alu_result_i;
        pc_plus4      <= bubble ? '0 : pc_plus4_i;
      end
    end
  end
endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed vectors checked against an instruction-level model and hand-computed literals.
module tb_writeback_stage;
  import core_pkg::*;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid_i, reg_write_i, flush_i, dmem_rvalid_i;
  logic [4:0]  rd_addr_i;
  logic [1:0]  wb_sel_i;
  logic [2:0]  funct3_i;
  logic [31:0] alu_result_i, pc_plus4_i, dmem_rdata_i;
  logic        stall_o, data_write_o;
  logic [4:0]  writereg_addr_o;
  logic [31:0] data_o, retire_count_o;
  int          n_cmp = 0;
  int          n_bad = 0;
  writeback_stage #(.address_width(5), .register_size(32)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .valid_i         (valid_i),
    .reg_write_i     (reg_write_i),
    .rd_addr_i       (rd_addr_i),
    .wb_sel_i        (wb_sel_i),
    .funct3_i        (funct3_i),
    .alu_result_i    (alu_result_i),
    .pc_plus4_i      (pc_plus4_i),
    .flush_i         (flush_i),
    .dmem_rdata_i    (dmem_rdata_i),
    .dmem_rvalid_i   (dmem_rvalid_i),
    .stall_o         (stall_o),
    .writereg_addr_o (writereg_addr_o),
    .data_o          (data_o),
    .data_write_o    (data_write_o),
    .retire_count_o  (retire_count_o)
  );
  always #5 clk = ~clk;
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] ref_align(logic [31:0] w, int off, logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> (8 * off));
    h = 16'(w >> (16 * (off / 2)));
    case (f3)
      3'd0: return 32'($signed(b));
      3'd4: return {24'd0, b};
      3'd1: return 32'($signed(h));
      3'd5: return {16'd0, h};
      default: return w;
    endcase
  endfunction
  // Model: the one instruction sitting in writeback, as the spec describes it.
  logic        m_valid, m_load, m_regw, m_pend;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  logic [31:0] m_addr, m_val, m_count;
  logic        e_stall, e_comp;
  always @(negedge clk) begin
    if (!reset_n) begin
      m_valid = 0; m_load = 0; m_regw = 0; m_pend = 0; m_rd = 0; m_f3 = 0;
      m_addr = 0; m_val = 0; m_count = 0;
      check("rst_stall", 32'(stall_o), 0);
      check("rst_we", 32'(data_write_o), 0);
      check("rst_addr", 32'(writereg_addr_o), 0);
      check("rst_data", data_o, 0);
      check("rst_count", retire_count_o, 0);
    end else begin
      e_stall = m_valid && m_load && !dmem_rvalid_i;
      e_comp  = m_valid && !e_stall;
      check("m_stall", 32'(stall_o), 32'(e_stall));
      check("m_we", 32'(data_write_o), 32'(e_comp && m_regw && m_rd != 0));
      check("m_count", retire_count_o, m_count);
      if (e_comp && m_regw) begin
        check("m_addr", 32'(writereg_addr_o), 32'(m_rd));
        check("m_data", data_o, m_load ? ref_align(dmem_rdata_i, int'(m_addr[1:0]), m_f3) : m_val);
      end
      if (e_comp) m_count = m_count + 1;
      if (e_stall) m_pend = m_pend | flush_i;
      else begin
        if (flush_i || m_pend || !valid_i) m_valid = 0;
        else begin
          m_valid = 1; m_regw = reg_write_i; m_rd = rd_addr_i; m_f3 = funct3_i;
          m_load = wb_sel_i == WB_LOAD; m_addr = alu_result_i;
          m_val = wb_sel_i == WB_PC4 ? pc_plus4_i : alu_result_i;
        end
        m_pend = 0;
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(logic v, logic rw, logic [4:0] rd, logic [1:0] sel, logic [2:0] f3,
                       logic [31:0] alu, logic [31:0] pc4);
    valid_i = v; reg_write_i = rw; rd_addr_i = rd; wb_sel_i = sel; funct3_i = f3;
    alu_result_i = alu; pc_plus4_i = pc4;
  endtask
  task automatic idle();
    drive(0, 0, 0, WB_ALU, 0, 0, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int          stalls;
    logic [31:0] c;
    reset_n = 1; flush_i = 0; dmem_rvalid_i = 0; dmem_rdata_i = 0;
    idle();
    #2 reset_n = 0;
    step(); step();
    reset_n = 1;
    drive(1, 1, 5, WB_ALU, 0, 32'h1234, 32'h100);
    step(); idle();
    @(negedge clk);
    check("alu_we", 32'(data_write_o), 1);
    check("alu_addr", 32'(writereg_addr_o), 5);
    check("alu_data", data_o, 32'h1234);
    check("alu_cnt0", retire_count_o, 0);
    step();
    check("alu_cnt1", retire_count_o, 1);
    drive(1, 1, 6, WB_LOAD, F3_LB, 32'h1003, 0);
    step();
    drive(1, 1, 7, WB_LOAD, F3_LBU, 32'h2003, 0);
    dmem_rdata_i = 32'h80FF_FF00; dmem_rvalid_i = 1;
    @(negedge clk);
    check("lb_stall", 32'(stall_o), 0);
    check("lb_we", 32'(data_write_o), 1);
    check("lb_data", data_o, 32'hFFFF_FF80);
    step(); idle();
    @(negedge clk);
    check("lbu_stall", 32'(stall_o), 0);
    check("lbu_data", data_o, 32'h0000_0080);
    step(); dmem_rvalid_i = 0;
    drive(1, 1, 8, WB_LOAD, F3_LH, 32'h3002, 0);
    step();
    drive(1, 1, 9, WB_ALU, 0, 32'h55, 0);
    stalls = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      stalls += int'(stall_o);
      check("lh_hold_addr", 32'(writereg_addr_o), 8);
      step();
    end
    check("lh_stall_cycles", 32'(stalls), 3);
    dmem_rdata_i = 32'h8001_1234; dmem_rvalid_i = 1;
    @(negedge clk);
    check("lh_stall_rel", 32'(stall_o), 0);
    check("lh_we", 32'(data_write_o), 1);
    check("lh_data", data_o, 32'hFFFF_8001);
    step(); dmem_rvalid_i = 0; idle();
    @(negedge clk);
    check("after_lh_addr", 32'(writereg_addr_o), 9);
    step();
    drive(1, 1, 10, WB_LOAD, F3_LW, 32'h4000, 0);
    step();
    drive(1, 1, 11, WB_ALU, 0, 32'h77, 0); flush_i = 1;
    step(); flush_i = 0;
    step();
    dmem_rdata_i = 32'hCAFE_F00D; dmem_rvalid_i = 1;
    @(negedge clk);
    check("flush_load_we", 32'(data_write_o), 1);
    check("flush_load_data", data_o, 32'hCAFE_F00D);
    c = retire_count_o;
    step(); dmem_rvalid_i = 0; idle();
    @(negedge clk);
    check("flush_bubble_we", 32'(data_write_o), 0);
    step();
    check("flush_bubble_cnt", retire_count_o, c + 1);
    drive(1, 1, 0, WB_ALU, 0, 32'h99, 0);
    step(); idle();
    @(negedge clk);
    c = retire_count_o;
    check("rd0_we", 32'(data_write_o), 0);
    step();
    check("rd0_cnt", retire_count_o, c + 1);
    drive(1, 1, 3, WB_PC4, 0, 32'h11, 32'h2004);
    step();
    drive(1, 1, 4, 2'b11, 0, 32'hABCD, 32'h9);
    @(negedge clk);
    check("pc4_data", data_o, 32'h2004);
    step(); idle();
    @(negedge clk);
    check("rsv_data", data_o, 32'hABCD);
    step();
    for (int f = 0; f < 8; f++)
      for (int o = 0; o < 4; o++) begin
        drive(1, 1, 5'(13 + o), WB_LOAD, 3'(f), 32'h5000 + 32'(o), 0);
        dmem_rdata_i = 32'(f * 4 + o) * 32'h0123_4567 ^ 32'h8080_8080;
        dmem_rvalid_i = 1;
        step();
      end
    idle();
    step(); dmem_rvalid_i = 0;
    drive(1, 1, 12, WB_LOAD, F3_LW, 32'h6000, 0);
    step(); idle();
    step();
    reset_n = 0;
    #1;
    check("rst_mid_stall", 32'(stall_o), 0);
    check("rst_mid_we", 32'(data_write_o), 0);
    check("rst_mid_addr", 32'(writereg_addr_o), 0);
    check("rst_mid_data", data_o, 0);
    check("rst_mid_cnt", retire_count_o, 0);
    step(); reset_n = 1;
    dmem_rdata_i = 32'h1111_2222; dmem_rvalid_i = 1;
    @(negedge clk);
    check("stray_we", 32'(data_write_o), 0);
    step(); dmem_rvalid_i = 0;
    step(); step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
